// File: rtl/bram_dsp_sequencer.sv
// Instruction-driven BRAM/DSP burst sequencer: streams len+1 elements from
// BRAM0/BRAM1 through the DSP and writes results back to BRAM1.
module bram_dsp_sequencer #(
   parameter int unsigned AW      = 5,
   parameter int unsigned LW      = 5,
   parameter int unsigned BRAM_AW = 10,
   parameter int unsigned DSP_LAT = 4,
   parameter int unsigned INST_W  = 17 + 3*AW + LW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INST_W-1:0]  inst,
   output logic [BRAM_AW-1:0] bram0_addr,
   output logic [BRAM_AW-1:0] bram1_raddr,
   output logic [BRAM_AW-1:0] bram1_waddr,
   output logic [3:0]         bram1_we,
   output logic               bram1_en,
   output logic [4:0]         dsp_inmode,
   output logic [6:0]         dsp_opmode,
   output logic [3:0]         dsp_alumode,
   output logic               busy,
   output logic               done
);

   localparam int unsigned LEN_LO  = 3*AW;
   localparam int unsigned INM_LO  = LEN_LO + LW;
   localparam int unsigned OPM_LO  = INM_LO + 5;
   localparam int unsigned ALU_LO  = OPM_LO + 7;
   localparam int unsigned EXE_BIT = ALU_LO + 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state, state_nx;
   logic               execute, last_execute, trigger;
   logic               issue, last_issue;
   logic [AW-1:0]      rd0, rd1, wa;
   logic [LW-1:0]      len_q;
   logic [LW:0]        cnt;
   logic [DSP_LAT-1:0] pipe, pipe_nx;

   assign execute    = inst[EXE_BIT];
   assign trigger    = execute && !last_execute;
   assign issue      = (state == S_RUN);
   assign last_issue = issue && (cnt == (LW+1)'(len_q));
   // Valid pipe shifts toward the MSB; the MSB marks a write-back cycle.
   assign pipe_nx    = DSP_LAT'({pipe, issue});

   assign bram0_addr  = BRAM_AW'(rd0);
   assign bram1_raddr = BRAM_AW'(rd1);
   assign bram1_waddr = BRAM_AW'(wa);
   assign bram1_we    = {4{pipe[DSP_LAT-1]}};
   assign bram1_en    = busy;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (trigger)          state_nx = S_RUN;
         S_RUN:   if (last_issue)       state_nx = S_DRAIN;
         S_DRAIN: if (pipe_nx == '0)    state_nx = S_DONE;
         S_DONE:  if (!execute)         state_nx = S_IDLE;
         default:                       state_nx = S_IDLE;
      endcase
   end

   // Datapath: latched instruction fields, address counters, valid pipe, status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_execute <= 1'b0;
         pipe         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rd0          <= '0;
         rd1          <= '0;
         wa           <= '0;
         len_q        <= '0;
         cnt          <= '0;
         dsp_inmode   <= '0;
         dsp_opmode   <= '0;
         dsp_alumode  <= '0;
      end else begin
         last_execute <= execute;
         pipe         <= pipe_nx;
         busy         <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
         done         <= (state_nx == S_DONE);
         if (state == S_IDLE && trigger) begin
            rd0         <= inst[AW-1:0];
            rd1         <= inst[2*AW-1:AW];
            wa          <= inst[3*AW-1:2*AW];
            len_q       <= inst[INM_LO-1:LEN_LO];
            cnt         <= '0;
            dsp_inmode  <= inst[OPM_LO-1:INM_LO];
            dsp_opmode  <= inst[ALU_LO-1:OPM_LO];
            dsp_alumode <= inst[EXE_BIT-1:ALU_LO];
         end else if (state == S_DONE && !execute) begin
            rd0         <= '0;
            rd1         <= '0;
            wa          <= '0;
            dsp_inmode  <= '0;
            dsp_opmode  <= '0;
            dsp_alumode <= '0;
         end else begin
            if (issue) begin
               rd0 <= rd0 + AW'(1);
               rd1 <= rd1 + AW'(1);
               cnt <= cnt + (LW+1)'(1);
            end
            if (pipe[DSP_LAT-1]) wa <= wa + AW'(1);
         end
      end
   end

endmodule

// File: tb/tb_bram_dsp_sequencer.sv
// Scoreboard bench for bram_dsp_sequencer: per-cycle read/write expectations
// are queued at trigger time and retired by a negedge monitor.
module tb_bram_dsp_sequencer;

   localparam int unsigned AW      = 5;
   localparam int unsigned LW      = 5;
   localparam int unsigned BRAM_AW = 10;
   localparam int unsigned DSP_LAT = 4;
   localparam int unsigned INST_W  = 17 + 3*AW + LW;

   logic               clk = 1'b0;
   logic               rst;
   logic [INST_W-1:0]  inst;
   logic [BRAM_AW-1:0] bram0_addr, bram1_raddr, bram1_waddr;
   logic [3:0]         bram1_we;
   logic               bram1_en;
   logic [4:0]         dsp_inmode;
   logic [6:0]         dsp_opmode;
   logic [3:0]         dsp_alumode;
   logic               busy, done;

   bram_dsp_sequencer #(.AW(AW), .LW(LW), .BRAM_AW(BRAM_AW), .DSP_LAT(DSP_LAT)) dut (
      .clk(clk), .rst(rst), .inst(inst),
      .bram0_addr(bram0_addr), .bram1_raddr(bram1_raddr), .bram1_waddr(bram1_waddr),
      .bram1_we(bram1_we), .bram1_en(bram1_en),
      .dsp_inmode(dsp_inmode), .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cyc;
      logic [BRAM_AW-1:0] a0;
      logic [BRAM_AW-1:0] a1;
   } exp_t;

   exp_t        rq[$];
   exp_t        wq[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          e_cyc;
   int          e_len;
   logic [15:0] e_modes;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [INST_W-1:0] mk(input logic ex, input logic [3:0] alu,
      input logic [6:0] op, input logic [4:0] inm, input logic [4:0] len,
      input logic [4:0] wa, input logic [4:0] r1, input logic [4:0] r0);
      return {ex, alu, op, inm, len, wa, r1, r0};
   endfunction

   function automatic logic [52:0] all_out();
      return {bram0_addr, bram1_raddr, bram1_waddr, bram1_we, bram1_en,
              dsp_inmode, dsp_opmode, dsp_alumode, busy, done};
   endfunction

   // Retire queued expectations on the cycle they are due.
   always @(negedge clk) begin
      if (!rst) begin
         if (rq.size() != 0 && rq[0].cyc == cyc) begin
            exp_t e;
            e = rq.pop_front();
            chk("rd", {bram0_addr, bram1_raddr, busy, bram1_en}, {e.a0, e.a1, 2'b11});
         end
         if (wq.size() != 0 && wq[0].cyc == cyc) begin
            exp_t e;
            e = wq.pop_front();
            chk("wr", {bram1_waddr, bram1_we, busy}, {e.a0, 4'hF, 1'b1});
         end else if (bram1_we != 4'h0) begin
            chk("wr_extra", bram1_we, 4'h0);
         end
      end
   end

   task automatic start(input int r0, input int r1, input int wa, input int len,
                        input logic [3:0] alu, input logic [6:0] op, input logic [4:0] inm);
      @(posedge clk); #1;
      inst    = mk(1'b1, alu, op, inm, 5'(len), 5'(wa), 5'(r1), 5'(r0));
      e_cyc   = cyc + 1;
      e_len   = len;
      e_modes = {alu, op, inm};
      for (int k = 0; k <= len; k++) begin
         exp_t e;
         e.cyc = e_cyc + k;
         e.a0  = BRAM_AW'((r0 + k) % 32);
         e.a1  = BRAM_AW'((r1 + k) % 32);
         rq.push_back(e);
         e.cyc = e_cyc + k + DSP_LAT;
         e.a0  = BRAM_AW'((wa + k) % 32);
         e.a1  = '0;
         wq.push_back(e);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 300);
      chk("done_seen", done, 1'b1);
      chk("done_cyc", cyc, e_cyc + e_len + DSP_LAT + 1);
      chk("modes", {dsp_alumode, dsp_opmode, dsp_inmode}, e_modes);
      chk("busy_at_done", {busy, bram1_en}, 2'b00);
   endtask

   task automatic finish_burst(input int hold);
      repeat (hold) begin
         @(negedge clk);
         chk("done_hold", {done, busy}, 2'b10);
      end
      @(posedge clk); #1;
      inst = '0;
      @(negedge clk);
      chk("done_before_drop", done, 1'b1);
      @(negedge clk);
      chk("idle", all_out(), 53'd0);
   endtask

   initial begin
      rst  = 1'b1;
      inst = '0;
      repeat (2) @(negedge clk);
      chk("reset", all_out(), 53'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // single element
      start(2, 3, 7, 0, 4'h3, 7'h35, 5'h11);
      wait_done();
      finish_burst(1);

      // burst with held execute and ignored instruction change
      start(0, 8, 16, 3, 4'hC, 7'h05, 5'h0A);
      @(posedge clk); #1;
      inst = mk(1'b1, 4'h1, 7'h01, 5'h01, 5'd9, 5'd1, 5'd2, 5'd3);
      wait_done();
      finish_burst(5);

      // address wrap
      start(30, 5, 29, 3, 4'h7, 7'h7F, 5'h1F);
      wait_done();
      finish_burst(2);

      // reset mid-burst
      start(4, 12, 20, 7, 4'h2, 7'h22, 5'h02);
      repeat (6) @(posedge clk);
      #1;
      rq.delete();
      wq.delete();
      rst  = 1'b1;
      inst = '0;
      #1;
      chk("rst_mid", all_out(), 53'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_rst_idle", all_out(), 53'd0);

      // early execute drop
      start(10, 11, 12, 2, 4'h9, 7'h44, 5'h04);
      @(posedge clk); #1;
      inst = '0;
      wait_done();
      @(negedge clk);
      chk("done_pulse", {done, busy}, 2'b00);
      @(negedge clk);
      chk("idle_after_pulse", all_out(), 53'd0);

      repeat (3) @(negedge clk);
      chk("queues_empty", 64'(rq.size() + wq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
